wbu_commit_arb: RTL and testbench

//  Writeback/commit arbiter downstream of the hazard unit's long-instruction tracker.

---
 rtl/alioth_wb_pkg.sv | 22 ++
 rtl/wbu_commit_arb_if.sv | 29 ++
 rtl/wbu_arb.sv | 57 +++++
 rtl/wbu_commit_arb.sv | 103 ++++++++++
 tb/tb_wbu_commit_arb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alioth_wb_pkg.sv
// Shared types and constants for the writeback/commit arbiter.
// Source indices double as the bit positions in every per-source vector.
package alioth_wb_pkg;

  localparam int N_SRC  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int ID_W   = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_CSR = 3;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ID_W-1:0]   commit_id;
  } wb_req_t;

endpackage

// File: rtl/wbu_commit_arb_if.sv
// Bundle between the result sources (master) and the commit arbiter (slave),
// covering both the source handshake and the regfile/commit outputs.
interface wbu_commit_arb_if;
  import alioth_wb_pkg::*;

  logic [N_SRC-1:0]             src_valid;
  logic [N_SRC-1:0]             src_ready;
  logic [N_SRC-1:0]             src_we;
  logic [N_SRC-1:0][ADDR_W-1:0] src_rd_addr;
  logic [N_SRC-1:0][DATA_W-1:0] src_rd_data;
  logic [N_SRC-1:0][ID_W-1:0]   src_commit_id;

  logic              reg_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              commit_valid;
  logic [ID_W-1:0]   commit_id;

  modport master (
    output src_valid, src_we, src_rd_addr, src_rd_data, src_commit_id,
    input  src_ready, reg_we, reg_waddr, reg_wdata, commit_valid, commit_id
  );

  modport slave (
    input  src_valid, src_we, src_rd_addr, src_rd_data, src_commit_id,
    output src_ready, reg_we, reg_waddr, reg_wdata, commit_valid, commit_id
  );

endinterface

// File: rtl/wbu_arb.sv
// Request vector to one-hot grant. Fixed priority DIV > MUL > CSR > ALU by default;
// defining WBU_RR_ARB_EN switches to round-robin with a pointer that resets to 0.
module wbu_arb
  import alioth_wb_pkg::*;
(
`ifdef WBU_RR_ARB_EN
  input  logic             clk,
  input  logic             rst_n,
`endif
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant
);

`ifdef WBU_RR_ARB_EN
  localparam int PTR_W = $clog2(N_SRC);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer; the winner's successor becomes the next starting point.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_SRC);
      if (req[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
        ptr_next   = PTR_W'((int'(idx) + 1) % N_SRC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end
`else
  always_comb begin
    grant = '0;
    if (req[SRC_DIV]) begin
      grant[SRC_DIV] = 1'b1;
    end else if (req[SRC_MUL]) begin
      grant[SRC_MUL] = 1'b1;
    end else if (req[SRC_CSR]) begin
      grant[SRC_CSR] = 1'b1;
    end else if (req[SRC_ALU]) begin
      grant[SRC_ALU] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/wbu_commit_arb.sv
// Writeback/commit arbiter: one hold register per result source, one grant per cycle,
// registered regfile write + commit pulse. Arbitration policy selected by WBU_RR_ARB_EN.
module wbu_commit_arb
  import alioth_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  wbu_commit_arb_if.slave   bus
);

  wb_req_t [N_SRC-1:0] hold;
  logic    [N_SRC-1:0] hold_v;
  logic    [N_SRC-1:0] grant;
  logic    [N_SRC-1:0] ready;
  logic    [N_SRC-1:0] take;
  logic                ready_en;
  wb_req_t             sel;

  logic              reg_we_q;
  logic [ADDR_W-1:0] reg_waddr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              commit_valid_q;
  logic [ID_W-1:0]   commit_id_q;

  wbu_arb u_arb (
`ifdef WBU_RR_ARB_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (hold_v),
    .grant (grant)
  );

  // Ready is held low through reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign ready = {N_SRC{ready_en}} & (~hold_v | grant);
  assign take  = bus.src_valid & ready;

  // A refill in the same cycle as a grant keeps the entry valid, so a streaming source never bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      hold_v <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (take[s]) begin
          hold[s]   <= '{we:        bus.src_we[s],
                         rd_addr:   bus.src_rd_addr[s],
                         rd_data:   bus.src_rd_data[s],
                         commit_id: bus.src_commit_id[s]};
          hold_v[s] <= 1'b1;
        end else if (grant[s]) begin
          hold_v[s] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (grant[s]) begin
        sel = hold[s];
      end
    end
  end

  // x0 writes still retire their ID; address/data only move on a real regfile write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q       <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
    end else begin
      reg_we_q       <= (|grant) & sel.we & (sel.rd_addr != '0);
      commit_valid_q <= |grant;
      if (|grant) begin
        commit_id_q <= sel.commit_id;
      end
      if ((|grant) && sel.we && (sel.rd_addr != '0)) begin
        reg_waddr_q <= sel.rd_addr;
        reg_wdata_q <= sel.rd_data;
      end
    end
  end

  assign bus.src_ready    = ready;
  assign bus.reg_we       = reg_we_q;
  assign bus.reg_waddr    = reg_waddr_q;
  assign bus.reg_wdata    = reg_wdata_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_id    = commit_id_q;

endmodule

// File: tb/tb_wbu_commit_arb.sv
// Directed bench for wbu_commit_arb; expectations for the streaming scenario
// follow WBU_RR_ARB_EN (round-robin) or the default fixed priority.
module tb_wbu_commit_arb;
  import alioth_wb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  wbu_commit_arb_if bus ();

  wbu_commit_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus.src_valid     = '0;
    bus.src_we        = '0;
    bus.src_rd_addr   = '0;
    bus.src_rd_data   = '0;
    bus.src_commit_id = '0;
  endtask

  task automatic drive(input int s, input logic we, input logic [ADDR_W-1:0] rd,
                       input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id);
    bus.src_valid[s]     = 1'b1;
    bus.src_we[s]        = we;
    bus.src_rd_addr[s]   = rd;
    bus.src_rd_data[s]   = d;
    bus.src_commit_id[s] = id;
  endtask

  function automatic int exp_src(input int k);
`ifdef WBU_RR_ARB_EN
    return k % 4;
`else
    if (k < 16)       return SRC_DIV;
    else if (k == 16) return SRC_MUL;
    else if (k == 17) return SRC_CSR;
    else              return SRC_ALU;
`endif
  endfunction

  function automatic int exp_seq(input int k);
`ifdef WBU_RR_ARB_EN
    return k / 4;
`else
    return (k < 16) ? k : 0;
`endif
  endfunction

  function automatic int exp_hs(input int s);
`ifdef WBU_RR_ARB_EN
    return (s == SRC_CSR) ? 4 : 5;
`else
    return (s == SRC_DIV) ? 16 : 1;
`endif
  endfunction

  task automatic test_reset;
    idle_all();
    rst_n = 1'b0;
    tick();
    total++; if (bus.src_ready !== 4'h0) $display("[TB] FAIL reset_ready: got %h expected 0", bus.src_ready); else passed++;
    total++; if (bus.reg_we !== 1'b0) $display("[TB] FAIL reset_reg_we: got %b expected 0", bus.reg_we); else passed++;
    total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL reset_commit_valid: got %b expected 0", bus.commit_valid); else passed++;
    total++; if ({bus.reg_waddr, bus.reg_wdata, bus.commit_id} !== '0)
      $display("[TB] FAIL reset_outputs: got %h/%h/%h expected 0", bus.reg_waddr, bus.reg_wdata, bus.commit_id); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (bus.src_ready !== 4'hF) $display("[TB] FAIL ready_after_release: got %h expected f", bus.src_ready); else passed++;
  endtask

  task automatic test_basic;
    drive(SRC_ALU, 1'b1, 5'd5, 32'h1234, 3'd2);
    tick();
    idle_all();
    total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL basic_early: got %b expected 0", bus.commit_valid); else passed++;
    tick();
    total++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 5'd5, 32'h1234})
      $display("[TB] FAIL basic_write: got we=%b a=%0d d=%h expected we=1 a=5 d=1234", bus.reg_we, bus.reg_waddr, bus.reg_wdata); else passed++;
    total++; if ({bus.commit_valid, bus.commit_id} !== {1'b1, 3'd2})
      $display("[TB] FAIL basic_commit: got v=%b id=%0d expected v=1 id=2", bus.commit_valid, bus.commit_id); else passed++;
    tick();
    total++; if ({bus.commit_valid, bus.reg_we} !== 2'b00)
      $display("[TB] FAIL basic_pulse: got v=%b we=%b expected 0 0", bus.commit_valid, bus.reg_we); else passed++;
  endtask

  task automatic test_priority;
    drive(SRC_ALU, 1'b1, 5'd1, 32'h0000_AAAA, 3'd0);
    drive(SRC_DIV, 1'b1, 5'd2, 32'h0000_BBBB, 3'd1);
    tick();
    idle_all();
    total++; if (bus.src_ready[SRC_ALU] !== 1'b0) $display("[TB] FAIL prio_alu_ready: got %b expected 0", bus.src_ready[SRC_ALU]); else passed++;
    total++; if (bus.src_ready[SRC_DIV] !== 1'b1) $display("[TB] FAIL prio_div_ready: got %b expected 1", bus.src_ready[SRC_DIV]); else passed++;
    tick();
    total++; if ({bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd1, 5'd2, 32'h0000_BBBB})
      $display("[TB] FAIL prio_div_first: got v=%b id=%0d a=%0d d=%h expected v=1 id=1 a=2 d=bbbb",
               bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata); else passed++;
    tick();
    total++; if ({bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd0, 5'd1, 32'h0000_AAAA})
      $display("[TB] FAIL prio_alu_second: got v=%b id=%0d a=%0d d=%h expected v=1 id=0 a=1 d=aaaa",
               bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata); else passed++;
    tick();
    total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL prio_drained: got %b expected 0", bus.commit_valid); else passed++;
  endtask

  task automatic test_x0;
    drive(SRC_MUL, 1'b1, 5'd0, 32'hDEAD_BEEF, 3'd4);
    tick();
    idle_all();
    tick();
    total++; if (bus.reg_we !== 1'b0) $display("[TB] FAIL x0_we: got %b expected 0", bus.reg_we); else passed++;
    total++; if ({bus.commit_valid, bus.commit_id} !== {1'b1, 3'd4})
      $display("[TB] FAIL x0_commit: got v=%b id=%0d expected v=1 id=4", bus.commit_valid, bus.commit_id); else passed++;
    total++; if ({bus.reg_waddr, bus.reg_wdata} !== {5'd1, 32'h0000_AAAA})
      $display("[TB] FAIL x0_hold_addr_data: got a=%0d d=%h expected a=1 d=aaaa", bus.reg_waddr, bus.reg_wdata); else passed++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        drive(SRC_MUL, 1'b1, 5'd3, 32'hC000 + 32'(i), ID_W'(i));
        total++; if (bus.src_ready[SRC_MUL] !== 1'b1)
          $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, bus.src_ready[SRC_MUL]); else passed++;
      end else begin
        idle_all();
      end
      tick();
      if (i == 0) begin
        total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL b2b_first: got %b expected 0", bus.commit_valid); else passed++;
      end else begin
        total++; if ({bus.commit_valid, bus.commit_id, bus.reg_wdata} !== {1'b1, ID_W'(i - 1), 32'hC000 + 32'(i - 1)})
          $display("[TB] FAIL b2b_commit_%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                   i, bus.commit_valid, bus.commit_id, bus.reg_wdata, i - 1, 32'hC000 + 32'(i - 1)); else passed++;
      end
    end
    tick();
    total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL b2b_end: got %b expected 0", bus.commit_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    drive(SRC_MUL, 1'b1, 5'd7, 32'h77, 3'd5);
    drive(SRC_CSR, 1'b1, 5'd8, 32'h88, 3'd6);
    tick();
    idle_all();
    tick();
    total++; if (bus.commit_valid !== 1'b1) $display("[TB] FAIL rst_mid_pre: got %b expected 1", bus.commit_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.reg_we, bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata} !== '0)
      $display("[TB] FAIL rst_mid_outputs: got we=%b v=%b id=%0d a=%0d d=%h expected all 0",
               bus.reg_we, bus.commit_valid, bus.commit_id, bus.reg_waddr, bus.reg_wdata); else passed++;
    total++; if (bus.src_ready !== 4'h0) $display("[TB] FAIL rst_mid_ready: got %h expected 0", bus.src_ready); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.commit_valid !== 1'b0) $display("[TB] FAIL rst_mid_no_commit_%0d: got %b expected 0", i, bus.commit_valid); else passed++;
    end
    total++; if (bus.src_ready !== 4'hF) $display("[TB] FAIL rst_mid_ready_back: got %h expected f", bus.src_ready); else passed++;
  endtask

  task automatic test_stream;
    int          seq[N_SRC];
    int          hs_cnt[N_SRC];
    logic [N_SRC-1:0] hs;
    int          k;
    int          got_src;
    int          got_seq;
    k = 0;
    for (int s = 0; s < N_SRC; s++) begin
      seq[s]    = 0;
      hs_cnt[s] = 0;
    end
    idle_all();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        for (int s = 0; s < N_SRC; s++) begin
          drive(s, 1'b1, ADDR_W'(s + 1), DATA_W'(s * 256 + seq[s]), ID_W'(seq[s]));
        end
      end else begin
        idle_all();
      end
      hs = bus.src_valid & bus.src_ready;
      tick();
      for (int s = 0; s < N_SRC; s++) begin
        if (hs[s]) begin
          seq[s]++;
          hs_cnt[s]++;
        end
      end
      if (bus.commit_valid === 1'b1) begin
        got_src = int'(bus.reg_wdata[15:8]);
        got_seq = int'(bus.reg_wdata[7:0]);
        total++; if (got_src !== exp_src(k) || got_seq !== exp_seq(k) || bus.reg_we !== 1'b1 ||
                     bus.commit_id !== ID_W'(exp_seq(k)) || bus.reg_waddr !== ADDR_W'(exp_src(k) + 1))
          $display("[TB] FAIL stream_commit_%0d: got src=%0d seq=%0d id=%0d we=%b expected src=%0d seq=%0d",
                   k, got_src, got_seq, bus.commit_id, bus.reg_we, exp_src(k), exp_seq(k)); else passed++;
        k++;
      end
    end
    total++; if (k !== 19) $display("[TB] FAIL stream_commit_count: got %0d expected 19", k); else passed++;
    for (int s = 0; s < N_SRC; s++) begin
      total++; if (hs_cnt[s] !== exp_hs(s))
        $display("[TB] FAIL stream_handshakes_%0d: got %0d expected %0d", s, hs_cnt[s], exp_hs(s)); else passed++;
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_priority();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
